// File: rtl/alu_share_ctrl.sv
// Shares one alu_top between two requesters: round-robin command accept, fixed
// operand settle time, tagged result response and display select.
module alu_share_ctrl #(
  parameter int width     = 6,
  parameter int ALU_LAT   = 1,
  parameter int OVF_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [width-1:0]       req0_a,
  input  logic [width-1:0]       req0_b,
  input  logic [1:0]             req0_func,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [width-1:0]       req1_a,
  input  logic [width-1:0]       req1_b,
  input  logic [1:0]             req1_func,
  output logic                   req1_ready,
  output logic [width-1:0]       alu_a,
  output logic [width-1:0]       alu_b,
  output logic [1:0]             alu_func,
  input  logic [2*width-1:0]     alu_out,
  input  logic                   alu_ovf,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [2*width-1:0]     rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   disp_result,
  output logic [OVF_CNT_W-1:0]   ovf_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0]           LAST_CNT = 4'(ALU_LAT - 1);
  localparam logic [OVF_CNT_W-1:0] OVF_MAX  = '1;

  state_t           state_reg;
  logic [3:0]       cnt_reg;
  logic             last_grant_reg;
  logic             grant;
  logic             accept;
  logic [width-1:0] sel_a;
  logic [width-1:0] sel_b;
  logic [1:0]       sel_func;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_reg == IDLE) && !grant;
  assign req1_ready = (state_reg == IDLE) && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel_a      = grant ? req1_a    : req0_a;
  assign sel_b      = grant ? req1_b    : req0_b;
  assign sel_func   = grant ? req1_func : req0_func;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_func       <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      busy           <= 1'b0;
      disp_result    <= 1'b0;
      ovf_count      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_a          <= sel_a;
            alu_b          <= sel_b;
            alu_func       <= sel_func;
            rsp_id         <= grant;
            last_grant_reg <= grant;
            cnt_reg        <= '0;
            disp_result    <= 1'b0;
            busy           <= 1'b1;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAST_CNT) begin
            rsp_data    <= alu_out;
            rsp_err     <= alu_ovf;
            disp_result <= 1'b1;
            rsp_valid   <= 1'b1;
            state_reg   <= RESP;
            if (alu_ovf && (ovf_count != OVF_MAX)) begin
              ovf_count <= ovf_count + 1'b1;
            end
          end
        end
        RESP: begin
          // Operands and display select stay put so the panel keeps the result.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (ALU_LAT=1/8-bit counter and
// ALU_LAT=3/2-bit counter) against a timing-level model of accept/response.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [5:0]  req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_func, req1_func;

  logic        r0_1, r1_1, rv_1, id_1, err_1, busy_1, disp_1, ovf_1_in;
  logic [5:0]  a_1, b_1;
  logic [1:0]  f_1;
  logic [11:0] data_1, out_1;
  logic [7:0]  cnt_1;

  logic        r0_3, r1_3, rv_3, id_3, err_3, busy_3, disp_3, ovf_3_in;
  logic [5:0]  a_3, b_3;
  logic [1:0]  f_3;
  logic [11:0] data_3, out_3;
  logic [1:0]  cnt_3;

  always #5 clk = ~clk;

  // ALU stub: concatenation result, overflow on function 3
  assign out_1 = {a_1, b_1};
  assign ovf_1_in = (f_1 == 2'd3);
  assign out_3 = {a_3, b_3};
  assign ovf_3_in = (f_3 == 2'd3);

  alu_share_ctrl #(.width(6), .ALU_LAT(1), .OVF_CNT_W(8)) u_lat1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func), .req0_ready(r0_1),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func), .req1_ready(r1_1),
    .alu_a(a_1), .alu_b(b_1), .alu_func(f_1), .alu_out(out_1), .alu_ovf(ovf_1_in),
    .rsp_valid(rv_1), .rsp_ready(rsp_ready), .rsp_id(id_1), .rsp_data(data_1), .rsp_err(err_1),
    .busy(busy_1), .disp_result(disp_1), .ovf_count(cnt_1));

  alu_share_ctrl #(.width(6), .ALU_LAT(3), .OVF_CNT_W(2)) u_lat3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func), .req0_ready(r0_3),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func), .req1_ready(r1_3),
    .alu_a(a_3), .alu_b(b_3), .alu_func(f_3), .alu_out(out_3), .alu_ovf(ovf_3_in),
    .rsp_valid(rv_3), .rsp_ready(rsp_ready), .rsp_id(id_3), .rsp_data(data_3), .rsp_err(err_3),
    .busy(busy_3), .disp_result(disp_3), .ovf_count(cnt_3));

  // Selected instance under observation
  logic        sel;
  logic        o_r0, o_r1, o_rv, o_id, o_err, o_busy, o_disp;
  logic [5:0]  o_a, o_b;
  logic [1:0]  o_f;
  logic [11:0] o_data;
  logic [7:0]  o_cnt;

  always_comb begin
    if (sel) begin
      o_r0 = r0_3; o_r1 = r1_3; o_rv = rv_3; o_id = id_3; o_err = err_3;
      o_busy = busy_3; o_disp = disp_3; o_a = a_3; o_b = b_3; o_f = f_3;
      o_data = data_3; o_cnt = {6'd0, cnt_3};
    end else begin
      o_r0 = r0_1; o_r1 = r1_1; o_rv = rv_1; o_id = id_1; o_err = err_1;
      o_busy = busy_1; o_disp = disp_1; o_a = a_1; o_b = b_1; o_f = f_1;
      o_data = data_1; o_cnt = cnt_1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one command in flight, response due a fixed number of
  // edges after its accept, ownership alternates under contention.
  int         t;
  bit         inflight;
  int         due;
  bit         last_g;
  bit [5:0]   e_a, e_b;
  bit [1:0]   e_f;
  bit [11:0]  e_data;
  bit         e_id, e_err, e_disp;
  int         e_cnt;
  int         acc_id[$];
  int         acc_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (sel=%0d t=%0d)", tag, obs, exp, sel, t);
    end
  endtask

  task automatic model_reset();
    inflight = 1'b0; due = 0; last_g = 1'b1;
    e_a = '0; e_b = '0; e_f = '0; e_data = '0; e_id = 1'b0; e_err = 1'b0;
    e_disp = 1'b0; e_cnt = 0;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 6'($urandom); req0_b = 6'($urandom); req0_func = 2'($urandom);
    req1_a = 6'($urandom); req1_b = 6'($urandom); req1_func = 2'($urandom);
  endtask

  // Called at a falling edge with inputs already driven; checks, clocks once,
  // updates the model and returns at the next falling edge.
  task automatic cyc();
    bit g, idle, rv, acc, hs;
    int lat, omax;
    lat  = sel ? 3 : 1;
    omax = sel ? 3 : 255;
    #1;
    idle = !inflight;
    if (req0_valid && req1_valid) g = !last_g;
    else g = req1_valid;
    rv = inflight && (t >= due);
    chk("req0_ready", 32'(o_r0), 32'(idle && !g));
    chk("req1_ready", 32'(o_r1), 32'(idle && g));
    chk("busy", 32'(o_busy), 32'(inflight));
    chk("rsp_valid", 32'(o_rv), 32'(rv));
    chk("alu_a", 32'(o_a), 32'(e_a));
    chk("alu_b", 32'(o_b), 32'(e_b));
    chk("alu_func", 32'(o_f), 32'(e_f));
    chk("disp_result", 32'(o_disp), 32'(e_disp));
    chk("ovf_count", 32'(o_cnt), 32'(e_cnt));
    if (rv) begin
      chk("rsp_data", 32'(o_data), 32'(e_data));
      chk("rsp_id", 32'(o_id), 32'(e_id));
      chk("rsp_err", 32'(o_err), 32'(e_err));
    end
    acc = idle && ((!g && req0_valid) || (g && req1_valid));
    hs  = rv && rsp_ready;
    if (!rst && o_r0 && req0_valid) begin acc_id.push_back(0); acc_t.push_back(t); end
    if (!rst && o_r1 && req1_valid) begin acc_id.push_back(1); acc_t.push_back(t); end
    @(posedge clk);
    t++;
    if (rst) begin
      model_reset();
    end else if (acc) begin
      inflight = 1'b1;
      due      = t + lat;
      e_a      = g ? req1_a : req0_a;
      e_b      = g ? req1_b : req0_b;
      e_f      = g ? req1_func : req0_func;
      e_data   = {e_a, e_b};
      e_err    = (e_f == 2'd3);
      e_id     = g;
      last_g   = g;
      e_disp   = 1'b0;
    end else if (hs) begin
      inflight = 1'b0;
    end
    if (!rst && inflight && t == due) begin
      e_disp = 1'b1;
      if (e_err && e_cnt < omax) e_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit s);
    sel = s;
    rst = 1'b1; rsp_ready = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    acc_id.delete(); acc_t.delete();
    chk("rst_rsp_data", 32'(o_data), 32'd0);
    chk("rst_rsp_id", 32'(o_id), 32'd0);
    chk("rst_rsp_err", 32'(o_err), 32'd0);
  endtask

  initial begin
    t = 0;
    sel = 1'b0;
    rst = 1'b1;
    rsp_ready = 1'b0;
    idle_inputs();
    model_reset();

    // Reset then single op, ALU_LAT=1
    do_reset(1'b0);
    cyc();
    req0_valid = 1'b1; req0_a = 6'h05; req0_b = 6'h2A; req0_func = 2'd0; rsp_ready = 1'b1;
    cyc();
    idle_inputs();
    cyc();
    chk("single_rsp_valid", 32'(o_rv), 32'd1);
    chk("single_rsp_data", 32'(o_data), 32'h16A);
    chk("single_rsp_id", 32'(o_id), 32'd0);
    chk("single_disp", 32'(o_disp), 32'd1);
    cyc();
    chk("single_busy_after", 32'(o_busy), 32'd0);
    repeat (2) cyc();

    // Contention: both valid continuously
    do_reset(1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 6'($urandom); req0_b = 6'($urandom); req0_func = 2'($urandom_range(0, 2));
      req1_a = 6'($urandom); req1_b = 6'($urandom); req1_func = 2'($urandom_range(0, 2));
      cyc();
    end
    idle_inputs();
    chk("contention_accepts", 32'(acc_id.size() >= 4), 32'd1);
    if (acc_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("grant_order", 32'(acc_id[k]), 32'(k % 2));
      for (int k = 0; k < 3; k++) chk("accept_spacing", 32'(acc_t[k+1] - acc_t[k]), 32'd3);
    end
    repeat (4) cyc();

    // Backpressure, ALU_LAT=3
    do_reset(1'b1);
    req0_valid = 1'b1; req0_a = 6'h3C; req0_b = 6'h11; req0_func = 2'd1;
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b1;
    repeat (3) cyc();
    chk("bp_rsp_valid", 32'(o_rv), 32'd1);
    repeat (10) begin
      req1_a = 6'($urandom); req1_b = 6'($urandom);
      cyc();
    end
    chk("bp_rsp_data", 32'(o_data), 32'hF11);
    chk("bp_alu_a", 32'(o_a), 32'h3C);
    rsp_ready = 1'b1;
    cyc();
    chk("bp_idle_busy", 32'(o_busy), 32'd0);
    cyc();
    req1_valid = 1'b0;
    repeat (6) cyc();

    // Saturating overflow counter, 2-bit
    do_reset(1'b1);
    rsp_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      req0_valid = 1'b1; req0_a = 6'($urandom); req0_b = 6'($urandom); req0_func = 2'd3;
      cyc();
      req0_valid = 1'b0;
      repeat (3) cyc();
      chk("ovf_rsp_err", 32'(o_err), 32'd1);
      chk("ovf_count_seq", 32'(o_cnt), 32'((k < 3) ? k : 3));
      cyc();
    end

    // Reset on the second EXEC cycle discards the pending response
    do_reset(1'b1);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 6'h2B; req0_b = 6'h07; req0_func = 2'd3;
    cyc();
    req0_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_ovf_count", 32'(o_cnt), 32'd0);
    chk("midrst_rsp_data", 32'(o_data), 32'd0);
    chk("midrst_alu_a", 32'(o_a), 32'd0);
    repeat (6) cyc();
    req1_valid = 1'b1; req1_a = 6'h12; req1_b = 6'h34; req1_func = 2'd2;
    cyc();
    req1_valid = 1'b0;
    repeat (3) cyc();
    chk("midrst_next_id", 32'(o_id), 32'd1);
    chk("midrst_next_valid", 32'(o_rv), 32'd1);
    cyc();

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      for (int i = 0; i < 400; i++) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req1_valid = ($urandom_range(0, 9) < 6);
        req0_a = 6'($urandom); req0_b = 6'($urandom); req0_func = 2'($urandom);
        req1_a = 6'($urandom); req1_b = 6'($urandom); req1_func = 2'($urandom);
        rsp_ready = $urandom_range(0, 1);
        rst = ($urandom_range(0, 59) == 0);
        cyc();
      end
      rst = 1'b0;
      idle_inputs();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencing controller that shares the single alu_top instance between two requesters (req0 = switch/panel front end, req1 = self-test or pattern source).
- Accepts operand/function commands over valid/ready, arbitrates round-robin, and drives the ALU operand/function inputs stable for a fixed settle time.
- Captures alu_top out/ovf and returns them on a tagged response channel; also drives the display select (operands vs result) for the top level.

Parameters:
- width, 6, operand width; ALU result is 2*width.
- ALU_LAT, 1, cycles operands are held before result capture; legal range 1..15.
- OVF_CNT_W, 8, width of saturating overflow counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 command valid
- req0_a  in  width  operand a
- req0_b  in  width  operand b
- req0_func  in  2  ALU function code
- req0_ready  out  1  requester 0 command accepted this cycle when high with valid
- req1_valid, req1_a, req1_b, req1_func, req1_ready  same as req0 for requester 1
- alu_a  out  width  to alu_top.a
- alu_b  out  width  to alu_top.b
- alu_func  out  2  to alu_top.func
- alu_out  in  2*width  from alu_top.out
- alu_ovf  in  1  from alu_top.ovf
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued the command
- rsp_data  out  2*width  captured alu_out
- rsp_err  out  1  captured alu_ovf
- busy  out  1  high in any state other than IDLE
- disp_result  out  1  0 = show operands, 1 = show result (top-level out_sel = ~disp_result)
- ovf_count  out  OVF_CNT_W  saturating count of responses with rsp_err=1

Behaviour:
- Reset (synchronous, active-high): state=IDLE; alu_a, alu_b, alu_func, rsp_data, rsp_id, rsp_err, disp_result, ovf_count = 0; rsp_valid=0; busy=0; last_grant=1, so req0 wins first contention.
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant is combinational. Only req0 valid -> grant 0. Only req1 valid -> grant 1. Both valid -> grant the requester != last_grant.
- reqN_ready = (state==IDLE) && (grant==N); at most one ready high per cycle; ready never high outside IDLE.
- Readiness does not depend on rsp_ready: the response channel is empty whenever state is IDLE.
- Accept edge (IDLE, valid&ready):
  - latch a/b/func into alu_a/alu_b/alu_func;
  - latch rsp_id=N and last_grant=N;
  - cnt=0; disp_result=0; state goes to EXEC.
- EXEC: alu_* held constant. Each edge cnt increments. On the edge where cnt==ALU_LAT-1:
  - rsp_data=alu_out, rsp_err=alu_ovf;
  - ovf_count += alu_ovf, saturating at all-ones, no wrap;
  - disp_result=1; state goes to RESP.
- Latency: rsp_valid rises exactly ALU_LAT edges after the accept edge.
- RESP: rsp_valid=1 and rsp_data/rsp_id/rsp_err stable until rsp_ready=1. On the handshake edge, state goes to IDLE and rsp_valid=0.
- alu_* and disp_result hold their last values after the handshake, until the next accept. Displays keep showing the result while idle.
- Back-to-back: a new command may be accepted the cycle after the response handshake, never in the same cycle. Throughput is one op per ALU_LAT+2 cycles minimum.
- Requester inputs are sampled only on the accept edge; changes while not ready are ignored. A requester that drops valid before grant loses nothing.
- Fairness: with both valid continuously, grants strictly alternate 0,1,0,1.
- Reset mid-EXEC or mid-RESP: the pending response is discarded (no rsp_valid) and all reset values apply on that edge.
- rst has priority over every handshake in the same cycle.
- Width rules: rsp_data is exactly 2*width. No sign handling in this block; the ALU owns arithmetic.

Test Plan:
- Bench uses an ALU stub alu_out={alu_a,alu_b}, alu_ovf=(alu_func==3).
- Reset: hold rst 2 cycles -> all outputs 0, last_grant effect = req0 priority, busy=0, rsp_valid=0.
- Single op, ALU_LAT=1: req0 a=6'h05, b=6'h2A, func=0, rsp_ready=1 -> req0_ready high in IDLE; rsp_valid 1 edge after accept; rsp_data=12'h16A, rsp_id=0, rsp_err=0; disp_result=1; busy back to 0 after the handshake.
- Contention: req0 and req1 valid continuously with distinct operands, rsp_ready=1 -> grant order 0,1,0,1 over 4 ops; each rsp_id matches; accept-to-accept spacing = ALU_LAT+2 cycles.
- Backpressure, ALU_LAT=3: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data stable, req0_ready/req1_ready stay 0, alu_a/alu_b unchanged; raise rsp_ready -> IDLE next edge.
- Overflow counter, OVF_CNT_W=2: issue 5 ops with func=3 -> rsp_err=1 each; ovf_count goes 1,2,3,3,3.
- Reset mid-op: assert rst on the 2nd EXEC cycle with ALU_LAT=3 -> no rsp_valid ever; all reset values; next req1-only command is accepted normally with rsp_id=1.
